// File: rtl/rv32_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I main controller: opcodes,
// ALUOp class codes, FSM state encoding and datapath mux selects.
package rv32_ctrl_pkg;

    // RV32I major opcodes (instr[6:0])
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // ALUOp class codes seen by the ALU-control decoder
    localparam logic [3:0] ALUOP_LOAD   = 4'b0000;
    localparam logic [3:0] ALUOP_OPIMM  = 4'b0001;
    localparam logic [3:0] ALUOP_AUIPC  = 4'b0010;
    localparam logic [3:0] ALUOP_STORE  = 4'b0011;
    localparam logic [3:0] ALUOP_OP     = 4'b0100;
    localparam logic [3:0] ALUOP_LUI    = 4'b0101;
    localparam logic [3:0] ALUOP_BRANCH = 4'b0110;
    localparam logic [3:0] ALUOP_JALR   = 4'b0111;
    localparam logic [3:0] ALUOP_JAL    = 4'b1000;

    // Instruction class; CLS_ILLEGAL marks an unrecognised opcode
    typedef enum logic [3:0] {
        CLS_LOAD    = 4'b0000,
        CLS_OPIMM   = 4'b0001,
        CLS_AUIPC   = 4'b0010,
        CLS_STORE   = 4'b0011,
        CLS_OP      = 4'b0100,
        CLS_LUI     = 4'b0101,
        CLS_BRANCH  = 4'b0110,
        CLS_JALR    = 4'b0111,
        CLS_JAL     = 4'b1000,
        CLS_ILLEGAL = 4'b1111
    } op_class_e;

    // FSM state encoding
    localparam int unsigned STATE_W = 3;
    localparam logic [STATE_W-1:0] ST_RESET   = 3'd0;
    localparam logic [STATE_W-1:0] ST_FETCH   = 3'd1;
    localparam logic [STATE_W-1:0] ST_DECODE  = 3'd2;
    localparam logic [STATE_W-1:0] ST_EXEC    = 3'd3;
    localparam logic [STATE_W-1:0] ST_MEM     = 3'd4;
    localparam logic [STATE_W-1:0] ST_WB      = 3'd5;
    localparam logic [STATE_W-1:0] ST_MEM_ERR = 3'd6;
    localparam logic [STATE_W-1:0] ST_TRAP    = 3'd7;

    // pc_src encodings
    localparam logic [1:0] PC_SRC_SEQ = 2'b00;
    localparam logic [1:0] PC_SRC_TGT = 2'b01;
    localparam logic [1:0] PC_SRC_ALU = 2'b10;

    // wb_sel encodings
    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_PC4  = 2'b10;
    localparam logic [1:0] WB_SEL_IMM  = 2'b11;

endpackage

// File: rtl/rv32_aluop_encoder.sv
// Combinational opcode classifier: opcode -> {class, ALUOp code, legal}.
module rv32_aluop_encoder
    import rv32_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_e  op_class,
    output logic [3:0] alu_op,
    output logic       legal
);

    // Map each recognised opcode to its class and ALUOp code
    always_comb begin
        op_class = CLS_ILLEGAL;
        alu_op   = ALUOP_LOAD;
        legal    = 1'b1;
        case (opcode)
            OPC_LOAD:   begin op_class = CLS_LOAD;   alu_op = ALUOP_LOAD;   end
            OPC_OPIMM:  begin op_class = CLS_OPIMM;  alu_op = ALUOP_OPIMM;  end
            OPC_AUIPC:  begin op_class = CLS_AUIPC;  alu_op = ALUOP_AUIPC;  end
            OPC_STORE:  begin op_class = CLS_STORE;  alu_op = ALUOP_STORE;  end
            OPC_OP:     begin op_class = CLS_OP;     alu_op = ALUOP_OP;     end
            OPC_LUI:    begin op_class = CLS_LUI;    alu_op = ALUOP_LUI;    end
            OPC_BRANCH: begin op_class = CLS_BRANCH; alu_op = ALUOP_BRANCH; end
            OPC_JALR:   begin op_class = CLS_JALR;   alu_op = ALUOP_JALR;   end
            OPC_JAL:    begin op_class = CLS_JAL;    alu_op = ALUOP_JAL;    end
            default:    legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/rv32_multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core.
// Sequences FETCH/DECODE/EXEC/MEM/WB over a single req/ready memory port.
// Optional build macro RV32_ILLEGAL_TRAP_EN: illegal opcodes set 'illegal'
// and park the FSM in TRAP; without it they retire as a NOP.
module rv32_multicycle_ctrl
    import rv32_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ir,
    input  logic [31:0] mem_rdata_ins,
    input  logic        mem_ready,
    input  logic        br_taken,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_ifetch,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic [3:0]  alu_op,
    output logic [3:0]  alu_funct,
    output logic        mem_err,
    output logic        illegal
);

    localparam bit TMO_EN = (TIMEOUT_CYCLES != 32'd0);
    // Last wait-count value before the timeout fires
    localparam logic [CNT_W-1:0] TMO_LAST =
        CNT_W'(TMO_EN ? (TIMEOUT_CYCLES - 32'd1) : 32'd0);

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mem_err_q, mem_err_d;
    op_class_e          op_class;
    logic [3:0]         enc_alu_op;
    logic               legal;
    logic               tmo_hit;
    logic               rd_nz;
    logic               is_store;

    // The instruction word itself is captured by the datapath, not here
    logic unused_bits;
    assign unused_bits = ^{mem_rdata_ins, ir[31], ir[29:15]};

    rv32_aluop_encoder u_enc (
        .opcode   (ir[6:0]),
        .op_class (op_class),
        .alu_op   (enc_alu_op),
        .legal    (legal)
    );

    assign rd_nz    = |ir[11:7];
    assign is_store = (op_class == CLS_STORE);
    assign tmo_hit  = TMO_EN && (cnt_q == TMO_LAST);
    assign mem_err  = mem_err_q;

`ifdef RV32_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    // State, wait counter and sticky flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RESET;
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
`ifdef RV32_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_err_q <= mem_err_d;
`ifdef RV32_ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    // Next-state and Moore-style control decode
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mem_err_d  = mem_err_q;
`ifdef RV32_ILLEGAL_TRAP_EN
        illegal_d  = illegal_q;
`endif
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_ifetch = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = PC_SRC_SEQ;
        reg_we     = 1'b0;
        wb_sel     = WB_SEL_ALU;
        alu_op     = ALUOP_LOAD;
        alu_funct  = 4'b0000;

        case (state_q)
            ST_RESET: state_d = ST_FETCH;

            ST_FETCH: begin
                mem_req    = 1'b1;
                mem_ifetch = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    state_d = ST_DECODE;
                end else if (tmo_hit) begin
                    mem_err_d = 1'b1;
                    state_d   = ST_MEM_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DECODE: begin
                if (legal) begin
                    state_d = ST_EXEC;
                end else begin
`ifdef RV32_ILLEGAL_TRAP_EN
                    illegal_d = 1'b1;
                    state_d   = ST_TRAP;
`else
                    state_d   = ST_WB;
`endif
                end
            end

            ST_EXEC: begin
                alu_op    = enc_alu_op;
                alu_funct = {ir[30], ir[14:12]};
                case (op_class)
                    CLS_BRANCH: begin
                        // Not-taken still advances PC by 4
                        pc_we   = 1'b1;
                        pc_src  = br_taken ? PC_SRC_TGT : PC_SRC_SEQ;
                        state_d = ST_FETCH;
                    end
                    CLS_LOAD, CLS_STORE: state_d = ST_MEM;
                    default:             state_d = ST_WB;
                endcase
            end

            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = is_store;
                if (mem_ready) begin
                    if (is_store) begin
                        pc_we   = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (tmo_hit) begin
                    mem_err_d = 1'b1;
                    state_d   = ST_MEM_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_WB: begin
                pc_we   = 1'b1;
                reg_we  = legal && rd_nz;
                state_d = ST_FETCH;
                case (op_class)
                    CLS_JAL:  begin pc_src = PC_SRC_TGT; wb_sel = WB_SEL_PC4; end
                    CLS_JALR: begin pc_src = PC_SRC_ALU; wb_sel = WB_SEL_PC4; end
                    CLS_LOAD: wb_sel = WB_SEL_LOAD;
                    CLS_LUI:  wb_sel = WB_SEL_IMM;
                    default:  ;
                endcase
            end

            ST_MEM_ERR: state_d = ST_MEM_ERR;
            ST_TRAP:    state_d = ST_TRAP;
            default:    state_d = ST_RESET;
        endcase

        // Wait counter restarts on every state change
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

endmodule

// File: tb/tb_rv32_multicycle_ctrl.sv
// Bench for rv32_multicycle_ctrl: latency/decode vector table, randomized
// instruction stream against a cycle-script reference model, and hand
// sequences for memory timeout, mid-operation reset and illegal opcodes.
module tb_rv32_multicycle_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] ir;
    logic [31:0] mem_rdata_ins;
    logic        mem_ready;
    logic        br_taken;
    logic        mem_req, mem_we, mem_ifetch, ir_we, pc_we, reg_we;
    logic [1:0]  pc_src, wb_sel;
    logic [3:0]  alu_op, alu_funct;
    logic        mem_err, illegal;

    int checks = 0;
    int errors = 0;

    rv32_multicycle_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ir            (ir),
        .mem_rdata_ins (mem_rdata_ins),
        .mem_ready     (mem_ready),
        .br_taken      (br_taken),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_ifetch    (mem_ifetch),
        .ir_we         (ir_we),
        .pc_we         (pc_we),
        .pc_src        (pc_src),
        .reg_we        (reg_we),
        .wb_sel        (wb_sel),
        .alu_op        (alu_op),
        .alu_funct     (alu_funct),
        .mem_err       (mem_err),
        .illegal       (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_ifetch;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       reg_we;
        logic [1:0] wb_sel;
        logic [3:0] alu_op;
        logic [3:0] alu_funct;
        logic       mem_err;
        logic       illegal;
    } out_t;

    // One expected clock cycle: inputs to drive and outputs required
    typedef struct {
        logic [31:0] ir;
        logic        ready;
        logic        br;
        out_t        o;
    } cyc_t;

    // Table vector: instruction, memory delay, expected latency/decode
    typedef struct {
        string       nm;
        logic [31:0] ir;
        logic        br;
        int          dly;
        int          lat;
        logic [3:0]  op;
        logic [3:0]  fn;
        logic [5:0]  last;   // {pc_we, pc_src, reg_we, wb_sel} of final cycle
    } vec_t;

    cyc_t exp_q[$];
    vec_t tbl[$];

    function automatic out_t sample();
        out_t o;
        o = {mem_req, mem_we, mem_ifetch, ir_we, pc_we, pc_src, reg_we,
             wb_sel, alu_op, alu_funct, mem_err, illegal};
        return o;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    // Instruction class number per the RV32I opcode map; -1 = illegal
    function automatic int cls_of(input logic [6:0] op);
        case (op)
            7'b0000011: return 0;
            7'b0010011: return 1;
            7'b0010111: return 2;
            7'b0100011: return 3;
            7'b0110011: return 4;
            7'b0110111: return 5;
            7'b1100011: return 6;
            7'b1100111: return 7;
            7'b1101111: return 8;
            default:    return -1;
        endcase
    endfunction

    function automatic void push(input logic [31:0] i, input logic rdy, input logic br, input out_t o);
        cyc_t c;
        c.ir = i; c.ready = rdy; c.br = br; c.o = o;
        exp_q.push_back(c);
    endfunction

    // Expand one instruction into its expected cycle script
    function automatic void model(input logic [31:0] i, input int fw, input int mw, input logic br);
        int         c;
        out_t       o;
        logic [3:0] fn;
        c  = cls_of(i[6:0]);
        fn = {i[30], i[14:12]};
        for (int k = 0; k < fw; k++) begin
            o = '0; o.mem_req = 1'b1; o.mem_ifetch = 1'b1;
            push(i, 1'b0, rbit(), o);
        end
        o = '0; o.mem_req = 1'b1; o.mem_ifetch = 1'b1; o.ir_we = 1'b1;
        push(i, 1'b1, rbit(), o);
        o = '0;
        push(i, rbit(), rbit(), o);
        if (c < 0) begin
            o = '0; o.pc_we = 1'b1;
            push(i, rbit(), rbit(), o);
            return;
        end
        o = '0; o.alu_op = 4'(c); o.alu_funct = fn;
        if (c == 6) begin
            o.pc_we = 1'b1; o.pc_src = br ? 2'b01 : 2'b00;
            push(i, rbit(), br, o);
            return;
        end
        push(i, rbit(), rbit(), o);
        if (c == 0 || c == 3) begin
            for (int k = 0; k < mw; k++) begin
                o = '0; o.mem_req = 1'b1; o.mem_we = (c == 3);
                push(i, 1'b0, rbit(), o);
            end
            o = '0; o.mem_req = 1'b1; o.mem_we = (c == 3); o.pc_we = (c == 3);
            push(i, 1'b1, rbit(), o);
            if (c == 3) return;
        end
        o = '0;
        o.pc_we  = 1'b1;
        o.reg_we = (i[11:7] != 5'd0);
        o.pc_src = (c == 8) ? 2'b01 : (c == 7) ? 2'b10 : 2'b00;
        o.wb_sel = (c == 7 || c == 8) ? 2'b10 : (c == 0) ? 2'b01 : (c == 5) ? 2'b11 : 2'b00;
        push(i, rbit(), rbit(), o);
    endfunction

    // Drive the queued script cycle by cycle and compare every cycle
    task automatic run_script(input string nm);
        cyc_t r;
        while (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            @(negedge clk);
            ir = r.ir; mem_ready = r.ready; br_taken = r.br;
            #1;
            check(nm, 32'(sample()), 32'(r.o));
        end
    endtask

    // Run one instruction with a responsive memory, measuring latency
    task automatic measure(input logic [31:0] i, input logic br, input int dly,
                           output int lat, output logic [3:0] ex_op,
                           output logic [3:0] ex_fn, output logic [5:0] last);
        int w;
        bit done;
        lat = 0; w = 0; done = 0; ex_op = 4'hx; ex_fn = 4'hx; last = 6'h0;
        ir = i; br_taken = br;
        while (!done && lat < 40) begin
            @(negedge clk);
            if (lat > 0 && mem_ifetch) begin
                done = 1;
            end else begin
                if (mem_req && !mem_ifetch) begin
                    mem_ready = (w >= dly);
                    w++;
                end else begin
                    mem_ready = mem_req;
                end
                #1;
                if (lat == 2) begin ex_op = alu_op; ex_fn = alu_funct; end
                last = {pc_we, pc_src, reg_we, wb_sel};
                lat++;
            end
        end
        mem_ready = 1'b0;
    endtask

    function automatic void add_vec(input string nm, input logic [31:0] i, input logic br,
                                    input int dly, input int lat, input logic [3:0] op,
                                    input logic [3:0] fn, input logic [5:0] last);
        vec_t v;
        v.nm = nm; v.ir = i; v.br = br; v.dly = dly; v.lat = lat;
        v.op = op; v.fn = fn; v.last = last;
        tbl.push_back(v);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int         lat;
        logic [3:0] eop, efn;
        logic [5:0] elast;
        logic [31:0] instr;
        logic [6:0] op;
        logic [6:0] legal_ops [9];
        out_t       o;

        legal_ops = '{7'b0000011, 7'b0010011, 7'b0010111, 7'b0100011, 7'b0110011,
                      7'b0110111, 7'b1100011, 7'b1100111, 7'b1101111};

        add_vec("add",     32'h002081B3, 1'b0, 0, 4, 4'b0100, 4'b0000, 6'b100100);
        add_vec("sub",     32'h40208233, 1'b0, 0, 4, 4'b0100, 4'b1000, 6'b100100);
        add_vec("srai",    32'h4020D213, 1'b0, 0, 4, 4'b0001, 4'b1101, 6'b100100);
        add_vec("load_w3", 32'h0000A183, 1'b0, 3, 8, 4'b0000, 4'b0010, 6'b100101);
        add_vec("load_w0", 32'h0000A183, 1'b0, 0, 5, 4'b0000, 4'b0010, 6'b100101);
        add_vec("beq_t",   32'h00208463, 1'b1, 0, 3, 4'b0110, 4'b0000, 6'b101000);
        add_vec("beq_nt",  32'h00208463, 1'b0, 0, 3, 4'b0110, 4'b0000, 6'b100000);
        add_vec("sw",      32'h0020A223, 1'b0, 0, 4, 4'b0011, 4'b0010, 6'b100000);
        add_vec("sw_w2",   32'h0020A223, 1'b0, 2, 6, 4'b0011, 4'b0010, 6'b100000);
        add_vec("jal_x0",  32'h0000006F, 1'b0, 0, 4, 4'b1000, 4'b0000, 6'b101010);
        add_vec("jalr",    32'h000080E7, 1'b0, 0, 4, 4'b0111, 4'b0000, 6'b110110);
        add_vec("lui",     32'h123450B7, 1'b0, 0, 4, 4'b0101, 4'b0101, 6'b100111);
        add_vec("auipc",   32'h00001517, 1'b0, 0, 4, 4'b0010, 4'b0001, 6'b100100);
`ifndef RV32_ILLEGAL_TRAP_EN
        add_vec("ill_nop", 32'hFFFFFFFF, 1'b0, 0, 3, 4'b0000, 4'b0000, 6'b100000);
`endif

        // Reset held 3 cycles with noisy inputs
        rst_n = 1'b0; ir = 32'h0; mem_rdata_ins = 32'h0; mem_ready = 1'b1; br_taken = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("in_reset", 32'(sample()), 32'h0);
        mem_ready = 1'b0; br_taken = 1'b0;
        rst_n = 1'b1;
        #1;
        check("reset_state", 32'(sample()), 32'h0);

        // Decode/latency table
        foreach (tbl[n]) begin
            measure(tbl[n].ir, tbl[n].br, tbl[n].dly, lat, eop, efn, elast);
            check({tbl[n].nm, "_latency"}, 32'(lat), 32'(tbl[n].lat));
            check({tbl[n].nm, "_alu_op"}, 32'(eop), 32'(tbl[n].op));
            check({tbl[n].nm, "_alu_funct"}, 32'(efn), 32'(tbl[n].fn));
            check({tbl[n].nm, "_final"}, 32'(elast), 32'(tbl[n].last));
        end

        // Randomized instruction stream vs cycle-script model
        for (int n = 0; n < 60; n++) begin
            op = legal_ops[$urandom_range(0, 8)];
`ifndef RV32_ILLEGAL_TRAP_EN
            if ($urandom_range(0, 7) == 0) begin
                op = 7'($urandom);
                for (int k = 0; k < 16 && cls_of(op) >= 0; k++) op = op + 7'd1;
            end
`endif
            instr = {25'($urandom), op};
            model(instr, $urandom_range(0, 2), $urandom_range(0, 3), rbit());
            run_script($sformatf("rand%0d_%h", n, instr));
        end

        // Fetch timeout: four wait cycles, then sticky MEM_ERR
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            mem_ready = 1'b0;
            #1;
            check($sformatf("tmo_wait%0d", k), {30'h0, mem_req, mem_err}, 32'h2);
        end
        o = '0; o.mem_err = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            mem_ready = 1'b1;
            #1;
            check($sformatf("mem_err_hold%0d", k), 32'(sample()), 32'(o));
        end
        mem_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check("mem_err_cleared", 32'(sample()), 32'h0);
        rst_n = 1'b1;
        measure(32'h002081B3, 1'b0, 0, lat, eop, efn, elast);
        check("resume_latency", 32'(lat), 32'd4);

        // Reset in the middle of a load's MEM phase
        ir = 32'h0000A183;
        @(negedge clk); mem_ready = 1'b1;
        @(negedge clk); mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("mid_mem_req", 32'(mem_req), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midop_reset", 32'(sample()), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef RV32_ILLEGAL_TRAP_EN
        // Illegal opcode traps and holds
        ir = 32'hFFFFFFFF;
        @(negedge clk);
        @(negedge clk); mem_ready = 1'b1;
        @(negedge clk); mem_ready = 1'b0;
        o = '0; o.illegal = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            mem_ready = 1'b1;
            #1;
            check($sformatf("trap_hold%0d", k), 32'(sample()), 32'(o));
        end
`else
        measure(32'hFFFFFFFF, 1'b0, 0, lat, eop, efn, elast);
        check("nop_latency", 32'(lat), 32'd3);
        check("nop_illegal", 32'(illegal), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
